uart_phy: RTL and testbench

Bit-level UART transceiver sitting directly downstream of the AXI UART register block. It consumes the block's `tx_en_o` / `tx_o` / `baud_div_o` / `rx_en_o` outputs and drives its `t_done_i` / `r_done_i` / `rx_i` inputs. Toward the pins it drives the serial TX line and samples the serial RX line. Frame format is fixed 8N1: one start bit, 8 data bits LSB first, one stop bit, no parity.

---
 rtl/uart_phy_if.sv | 37 +++
 rtl/uart_phy.sv | 229 ++++++++++++++++++++++
 tb/tb_uart_phy.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_phy_if.sv
// -----------------------------------------------------------------------------
// uart_phy_if
// Handshake bundle between the AXI UART register block (master) and the
// bit-level UART PHY (slave). Signal names follow the PHY's point of view.
//   tx_en_i       : TX request, tx_data_i valid while high
//   tx_data_i     : byte to transmit
//   baud_div_i    : bit period in clocks
//   rx_en_i       : receiver enable
//   t_done_o      : 1-cycle pulse, frame transmitted
//   r_done_o      : 1-cycle pulse, byte received
//   rx_data_o     : last good received byte
//   framing_err_o : 1-cycle pulse, stop bit sampled low
//   tx_busy_o     : TX FSM not idle
//   rx_busy_o     : RX FSM not idle
// -----------------------------------------------------------------------------
interface uart_phy_if;
  logic        tx_en_i;
  logic [7:0]  tx_data_i;
  logic [15:0] baud_div_i;
  logic        rx_en_i;
  logic        t_done_o;
  logic        r_done_o;
  logic [7:0]  rx_data_o;
  logic        framing_err_o;
  logic        tx_busy_o;
  logic        rx_busy_o;

  modport master (
    output tx_en_i, tx_data_i, baud_div_i, rx_en_i,
    input  t_done_o, r_done_o, rx_data_o, framing_err_o, tx_busy_o, rx_busy_o
  );

  modport slave (
    input  tx_en_i, tx_data_i, baud_div_i, rx_en_i,
    output t_done_o, r_done_o, rx_data_o, framing_err_o, tx_busy_o, rx_busy_o
  );
endinterface

// File: rtl/uart_phy.sv
// -----------------------------------------------------------------------------
// uart_phy
// Bit-level 8N1 UART transceiver driven by the AXI UART register block.
//   s_axi_aclk_i    : system clock
//   s_axi_aresetn_i : asynchronous active-low reset
//   reg_if          : register-block handshake (uart_phy_if.slave)
//   txd_o           : serial TX line, idles high, registered
//   rxd_i           : serial RX line, asynchronous to the clock
// Parameters:
//   SYNC_STAGES : RX synchronizer depth (>= 2)
//   MIN_DIV     : smallest bit period in clocks (baud_div_i is clamped to it)
// -----------------------------------------------------------------------------
module uart_phy #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_DIV     = 4
) (
  input  logic      s_axi_aclk_i,
  input  logic      s_axi_aresetn_i,
  uart_phy_if.slave reg_if,
  output logic      txd_o,
  input  logic      rxd_i
);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_HOLD} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  localparam logic [15:0] MIN_D = 16'(MIN_DIV);

  // Effective divider, latched separately by each FSM at frame start.
  logic [15:0] w_div_eff;
  assign w_div_eff = (reg_if.baud_div_i < MIN_D) ? MIN_D : reg_if.baud_div_i;

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  tx_state_t   r_tx_state;
  logic [15:0] r_tx_div;
  logic [15:0] r_tx_cnt;
  logic [2:0]  r_tx_bit;
  logic [7:0]  r_tx_shift;
  logic        r_txd;
  logic        r_t_done;
  logic        r_tx_busy;
  logic        w_tx_last;

  assign w_tx_last = (r_tx_cnt == r_tx_div - 16'd1);

  always_ff @(posedge s_axi_aclk_i or negedge s_axi_aresetn_i) begin
    if (!s_axi_aresetn_i) begin
      r_tx_state <= TX_IDLE;
      r_tx_div   <= MIN_D;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_txd      <= 1'b1;
      r_t_done   <= 1'b0;
      r_tx_busy  <= 1'b0;
    end else begin
      r_t_done <= 1'b0;
      r_tx_cnt <= w_tx_last ? 16'd0 : r_tx_cnt + 16'd1;
      case (r_tx_state)
        TX_IDLE: begin
          r_tx_cnt <= '0;
          if (reg_if.tx_en_i) begin
            r_tx_shift <= reg_if.tx_data_i;
            r_tx_div   <= w_div_eff;
            r_tx_bit   <= '0;
            r_txd      <= 1'b0;
            r_tx_busy  <= 1'b1;
            r_tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (w_tx_last) begin
            r_txd      <= r_tx_shift[0];
            r_tx_state <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (w_tx_last) begin
            if (r_tx_bit == 3'd7) begin
              r_txd      <= 1'b1;
              r_tx_state <= TX_STOP;
            end else begin
              r_tx_bit   <= r_tx_bit + 3'd1;
              r_tx_shift <= r_tx_shift >> 1;
              r_txd      <= r_tx_shift[1];
            end
          end
        end
        TX_STOP: begin
          // Registered pulse: set one cycle early so it lands in the last stop cycle.
          if (r_tx_cnt == r_tx_div - 16'd2) r_t_done <= 1'b1;
          if (w_tx_last) r_tx_state <= TX_HOLD;
        end
        TX_HOLD: begin
          // Two quiet cycles give the register block time to refresh tx_en/tx_data.
          if (r_tx_cnt == 16'd1) begin
            r_tx_state <= TX_IDLE;
            r_tx_busy  <= 1'b0;
          end
        end
        default: begin
          r_tx_state <= TX_IDLE;
          r_tx_busy  <= 1'b0;
          r_txd      <= 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_rx_sync;
  logic                   r_rs_prev;
  logic                   w_rs;
  logic                   w_rx_fall;

  assign w_rs      = r_rx_sync[SYNC_STAGES-1];
  assign w_rx_fall = r_rs_prev & ~w_rs;

  always_ff @(posedge s_axi_aclk_i or negedge s_axi_aresetn_i) begin
    if (!s_axi_aresetn_i) begin
      r_rx_sync <= '1;
      r_rs_prev <= 1'b1;
    end else begin
      r_rx_sync <= {r_rx_sync[SYNC_STAGES-2:0], rxd_i};
      r_rs_prev <= w_rs;
    end
  end

  rx_state_t   r_rx_state;
  logic [15:0] r_rx_div;
  logic [15:0] r_rx_cnt;
  logic [2:0]  r_rx_bit;
  logic [7:0]  r_rx_shift;
  logic [7:0]  r_rx_data;
  logic        r_r_done;
  logic        r_ferr;
  logic        r_rx_busy;
  logic        w_rx_half;
  logic        w_rx_full;

  // Start bit is checked at its middle; every later sample is a full period on.
  assign w_rx_half = (r_rx_cnt == (r_rx_div >> 1) - 16'd1);
  assign w_rx_full = (r_rx_cnt == r_rx_div - 16'd1);

  always_ff @(posedge s_axi_aclk_i or negedge s_axi_aresetn_i) begin
    if (!s_axi_aresetn_i) begin
      r_rx_state <= RX_IDLE;
      r_rx_div   <= MIN_D;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_r_done   <= 1'b0;
      r_ferr     <= 1'b0;
      r_rx_busy  <= 1'b0;
    end else begin
      r_r_done <= 1'b0;
      r_ferr   <= 1'b0;
      r_rx_cnt <= r_rx_cnt + 16'd1;
      if (r_rx_state != RX_IDLE && !reg_if.rx_en_i) begin
        // Receiver disabled mid-frame: drop everything silently.
        r_rx_state <= RX_IDLE;
        r_rx_busy  <= 1'b0;
        r_rx_cnt   <= '0;
      end else begin
        case (r_rx_state)
          RX_IDLE: begin
            r_rx_cnt <= '0;
            if (reg_if.rx_en_i && w_rx_fall) begin
              r_rx_div   <= w_div_eff;
              r_rx_busy  <= 1'b1;
              r_rx_state <= RX_START;
            end
          end
          RX_START: begin
            if (w_rx_half) begin
              r_rx_cnt <= '0;
              r_rx_bit <= '0;
              if (w_rs) begin
                // Line back high at mid-start: glitch, not a frame.
                r_rx_state <= RX_IDLE;
                r_rx_busy  <= 1'b0;
              end else begin
                r_rx_state <= RX_DATA;
              end
            end
          end
          RX_DATA: begin
            if (w_rx_full) begin
              r_rx_cnt   <= '0;
              r_rx_shift <= {w_rs, r_rx_shift[7:1]};
              if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
              else                  r_rx_bit   <= r_rx_bit + 3'd1;
            end
          end
          RX_STOP: begin
            if (w_rx_full) begin
              if (w_rs) begin
                r_rx_data <= r_rx_shift;
                r_r_done  <= 1'b1;
              end else begin
                r_ferr <= 1'b1;
              end
              r_rx_state <= RX_IDLE;
              r_rx_busy  <= 1'b0;
            end
          end
          default: begin
            r_rx_state <= RX_IDLE;
            r_rx_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign txd_o                = r_txd;
  assign reg_if.t_done_o      = r_t_done;
  assign reg_if.tx_busy_o     = r_tx_busy;
  assign reg_if.r_done_o      = r_r_done;
  assign reg_if.framing_err_o = r_ferr;
  assign reg_if.rx_data_o     = r_rx_data;
  assign reg_if.rx_busy_o     = r_rx_busy;

endmodule

// File: tb/tb_uart_phy.sv
// -----------------------------------------------------------------------------
// tb_uart_phy
// Self-checking bench for uart_phy. Expected TX waveforms and RX pulse timing
// come from the frame rules (bit index = elapsed cycles / D) and the last-good
// byte model; RX outputs are captured into queues by a negedge monitor.
// -----------------------------------------------------------------------------
module tb_uart_phy;
  localparam int SS    = 2;
  localparam int MIN_D = 4;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic tb_rxd  = 1'b1;
  logic loop_en = 1'b0;
  logic txd;
  logic w_rxd;

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;

  int         done_q[$];
  logic [7:0] done_data_q[$];
  int         ferr_q[$];

  typedef struct {
    logic [7:0]  data;
    logic [15:0] div;
    int          exp_period;
  } tx_vec_t;

  typedef struct {
    logic [7:0]  data;
    logic [15:0] div;
    logic        stop;
    int          exp_done;
    int          exp_ferr;
    logic [7:0]  exp_data;
  } rx_vec_t;

  tx_vec_t tx_tab[4];
  rx_vec_t rx_tab[5];

  uart_phy_if u_if();

  assign w_rxd = loop_en ? txd : tb_rxd;

  uart_phy #(.SYNC_STAGES(SS), .MIN_DIV(MIN_D)) dut (
    .s_axi_aclk_i   (clk),
    .s_axi_aresetn_i(rst_n),
    .reg_if         (u_if),
    .txd_o          (txd),
    .rxd_i          (w_rxd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every RX pulse with the index of the clock edge that produced it.
  always @(negedge clk) begin
    if (u_if.r_done_o) begin
      done_q.push_back(cyc);
      done_data_q.push_back(u_if.rx_data_o);
    end
    if (u_if.framing_err_o) ferr_q.push_back(cyc);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  function automatic int eff(input logic [15:0] d);
    if (d < 16'(MIN_D)) return MIN_D;
    return int'(d);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_q();
    done_q.delete();
    done_data_q.delete();
    ferr_q.delete();
  endtask

  // Called right after the edge that sampled tx_en; walks the whole frame
  // plus HOLD and the following IDLE cycle, comparing against the 8N1 rules.
  task automatic tx_frame_check(input logic [7:0] data, input int d, input string name);
    int   bad;
    int   first_t;
    int   bp;
    logic exp_txd;
    logic act_txd, act_done, act_busy;
    bad = 0;
    first_t = 0;
    act_txd = 1'b0; act_done = 1'b0; act_busy = 1'b0;
    for (int t = 1; t <= 10 * d + 3; t++) begin
      @(negedge clk);
      bp = (t - 1) / d;
      if (t > 10 * d)  exp_txd = 1'b1;
      else if (bp == 0) exp_txd = 1'b0;
      else if (bp <= 8) exp_txd = data[bp-1];
      else              exp_txd = 1'b1;
      if (txd !== exp_txd || u_if.t_done_o !== (t == 10 * d) ||
          u_if.tx_busy_o !== (t <= 10 * d + 2)) begin
        if (bad == 0) begin
          first_t  = t;
          act_txd  = txd;
          act_done = u_if.t_done_o;
          act_busy = u_if.tx_busy_o;
        end
        bad++;
      end
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s: %0d bad cycles, first at t=%0d txd=%b t_done=%b busy=%b (data=0x%02h D=%0d)",
               name, bad, first_t, act_txd, act_done, act_busy, data, d);
    end
  endtask

  task automatic send_tx(input logic [7:0] data, input logic [15:0] div, input int d,
                         input string name, output int n);
    @(negedge clk);
    u_if.tx_data_i  = data;
    u_if.baud_div_i = div;
    u_if.tx_en_i    = 1'b1;
    @(posedge clk);
    #1;
    n = cyc;
    u_if.tx_en_i = 1'b0;
    $display("tx %s: data=0x%02h baud_div=%0d start_edge=%0d", name, data, div, n);
    tx_frame_check(data, d, name);
  endtask

  // Drives one frame on the RX pin; k is the first clock edge that sees the start bit.
  task automatic drive_rx(input logic [7:0] data, input int d, input logic stop, output int k);
    @(negedge clk);
    tb_rxd = 1'b0;
    k = cyc + 1;
    repeat (d) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      tb_rxd = data[i];
      repeat (d) @(negedge clk);
    end
    tb_rxd = stop;
    repeat (d) @(negedge clk);
    tb_rxd = 1'b1;
    repeat (d) @(negedge clk);
    $display("rx frame: data=0x%02h D=%0d stop=%b start_edge=%0d", data, d, stop, k);
  endtask

  task automatic rx_result(input string name, input int exp_done, input int exp_ferr,
                           input int exp_cyc, input logic [7:0] exp_data);
    check({name, "_done_cnt"}, done_q.size(), exp_done);
    check({name, "_ferr_cnt"}, ferr_q.size(), exp_ferr);
    if (done_q.size() > 0) begin
      check({name, "_done_time"}, done_q[0], exp_cyc);
      check({name, "_done_data"}, done_data_q[0], exp_data);
    end
    if (ferr_q.size() > 0) check({name, "_ferr_time"}, ferr_q[0], exp_cyc);
    check({name, "_rx_data"}, u_if.rx_data_o, exp_data);
    check({name, "_rx_busy"}, u_if.rx_busy_o, 1'b0);
  endtask

  initial begin
    int          n, k, d, bad, mode;
    logic [7:0]  data, model_rx;
    logic [15:0] div;
    logic        stop;

    tx_tab[0] = '{8'hA5, 16'd16, 16};
    tx_tab[1] = '{8'h3C, 16'd2,  4};
    tx_tab[2] = '{8'h00, 16'd5,  5};
    tx_tab[3] = '{8'hFF, 16'd0,  4};

    rx_tab[0] = '{8'hC3, 16'd16, 1'b1, 1, 0, 8'hC3};
    rx_tab[1] = '{8'h55, 16'd16, 1'b0, 0, 1, 8'hC3};
    rx_tab[2] = '{8'h01, 16'd2,  1'b1, 1, 0, 8'h01};
    rx_tab[3] = '{8'h80, 16'd7,  1'b1, 1, 0, 8'h80};
    rx_tab[4] = '{8'hFF, 16'd5,  1'b0, 0, 1, 8'h80};

    u_if.tx_en_i    = 1'b0;
    u_if.tx_data_i  = 8'h00;
    u_if.baud_div_i = 16'd16;
    u_if.rx_en_i    = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_txd",      txd, 1'b1);
    check("rst_t_done",   u_if.t_done_o, 1'b0);
    check("rst_r_done",   u_if.r_done_o, 1'b0);
    check("rst_ferr",     u_if.framing_err_o, 1'b0);
    check("rst_tx_busy",  u_if.tx_busy_o, 1'b0);
    check("rst_rx_busy",  u_if.rx_busy_o, 1'b0);
    check("rst_rx_data",  u_if.rx_data_o, 8'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_txd", txd, 1'b1);

    // TX vectors
    for (int i = 0; i < 4; i++)
      send_tx(tx_tab[i].data, tx_tab[i].div, tx_tab[i].exp_period, "tx_tab", n);

    // Back-to-back frames with tx_en held high
    @(negedge clk);
    u_if.tx_data_i  = 8'h11;
    u_if.baud_div_i = 16'd16;
    u_if.tx_en_i    = 1'b1;
    @(posedge clk);
    #1;
    fork
      tx_frame_check(8'h11, 16, "b2b_first");
      begin
        repeat (161) @(negedge clk);
        u_if.tx_data_i = 8'h22;
      end
    join
    @(posedge clk);
    #1;
    u_if.tx_en_i = 1'b0;
    tx_frame_check(8'h22, 16, "b2b_second");

    // Divider change mid-frame only affects the next frame
    fork
      send_tx(8'h5A, 16'd16, 16, "div_change", n);
      begin
        repeat (50) @(negedge clk);
        u_if.baud_div_i = 16'd32;
      end
    join
    u_if.baud_div_i = 16'd16;

    // Loopback
    loop_en = 1'b1;
    clear_q();
    send_tx(8'h3C, 16'd16, 16, "loopback", n);
    repeat (2) @(negedge clk);
    rx_result("loopback", 1, 0, n + 1 + SS + 8 + 9 * 16, 8'h3C);
    loop_en = 1'b0;

    // RX vectors
    for (int i = 0; i < 5; i++) begin
      clear_q();
      u_if.baud_div_i = rx_tab[i].div;
      d = eff(rx_tab[i].div);
      drive_rx(rx_tab[i].data, d, rx_tab[i].stop, k);
      repeat (4) @(negedge clk);
      rx_result("rx_tab", rx_tab[i].exp_done, rx_tab[i].exp_ferr,
                k + SS + d / 2 + 9 * d, rx_tab[i].exp_data);
    end
    model_rx = 8'h80;

    // 5-cycle glitch: false start, no outputs
    u_if.baud_div_i = 16'd16;
    clear_q();
    @(negedge clk);
    tb_rxd = 1'b0;
    repeat (4) @(negedge clk);
    check("glitch_busy", u_if.rx_busy_o, 1'b1);
    @(negedge clk);
    tb_rxd = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_done_cnt", done_q.size(), 0);
    check("glitch_ferr_cnt", ferr_q.size(), 0);
    check("glitch_rx_busy",  u_if.rx_busy_o, 1'b0);
    check("glitch_rx_data",  u_if.rx_data_o, model_rx);

    // rx_en dropped mid-frame aborts silently
    clear_q();
    fork
      drive_rx(8'hA5, 16, 1'b1, k);
      begin
        repeat (60) @(negedge clk);
        check("rxen_abort_busy_before", u_if.rx_busy_o, 1'b1);
        u_if.rx_en_i = 1'b0;
        @(negedge clk);
        check("rxen_abort_busy_after", u_if.rx_busy_o, 1'b0);
      end
    join
    u_if.rx_en_i = 1'b1;
    repeat (4) @(negedge clk);
    check("rxen_abort_done_cnt", done_q.size(), 0);
    check("rxen_abort_ferr_cnt", ferr_q.size(), 0);

    // Reset in the middle of TX DATA
    @(negedge clk);
    u_if.tx_data_i  = 8'h81;
    u_if.baud_div_i = 16'd16;
    u_if.tx_en_i    = 1'b1;
    @(posedge clk);
    #1;
    u_if.tx_en_i = 1'b0;
    repeat (40) @(negedge clk);
    check("midrst_pre_txd",  txd, 1'b0);
    check("midrst_pre_busy", u_if.tx_busy_o, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_async_txd", txd, 1'b1);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (u_if.t_done_o || u_if.r_done_o || u_if.framing_err_o ||
          u_if.tx_busy_o || u_if.rx_busy_o || !txd) bad++;
    end
    check("midrst_quiet", bad, 0);
    rst_n = 1'b1;
    model_rx = 8'h00;
    send_tx(8'h81, 16'd16, 16, "post_reset", n);
    check("post_reset_rx_data", u_if.rx_data_o, model_rx);

    // Randomized traffic against the frame model
    for (int it = 0; it < 24; it++) begin
      data = 8'($urandom);
      div  = 16'($urandom_range(0, 24));
      d    = eff(div);
      mode = $urandom_range(0, 2);
      clear_q();
      if (mode < 2) begin
        loop_en = 1'b1;
        send_tx(data, div, d, "rnd_loop", n);
        repeat (2) @(negedge clk);
        model_rx = data;
        rx_result("rnd_loop", 1, 0, n + 1 + SS + d / 2 + 9 * d, model_rx);
        loop_en = 1'b0;
      end else begin
        stop = 1'($urandom_range(0, 1));
        u_if.baud_div_i = div;
        drive_rx(data, d, stop, k);
        repeat (4) @(negedge clk);
        if (stop) model_rx = data;
        rx_result("rnd_rx", stop ? 1 : 0, stop ? 0 : 1, k + SS + d / 2 + 9 * d, model_rx);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
